// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core: load-use stalls, branch
// flushes and external freeze, with saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int LU_STALL_CYCLES = 1,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr_IFID,
  input  logic [4:0]       rd_IDEX,
  input  logic             memRead_IDEX,
  input  logic             branch_taken_EX,
  input  logic             ext_stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic [1:0]       hz_state,
  output logic [CNT_W-1:0] lu_stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1
  } hz_state_e;

  localparam logic [1:0] REM_LOAD = 2'(LU_STALL_CYCLES - 1);

  hz_state_e        state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] fl_cnt_q, fl_cnt_d;

  logic [6:0] opcode;
  logic [4:0] rs1, rs2;
  logic       rs1_used, rs2_used;
  logic       lu_hit;

  // Only opcodes that actually read rs1/rs2 may raise a hazard; x0 never does.
  always_comb begin
    opcode   = instr_IFID[6:0];
    rs1      = instr_IFID[19:15];
    rs2      = instr_IFID[24:20];
    rs1_used = opcode inside {7'b0110011, 7'b0010011, 7'b0000011,
                              7'b0100011, 7'b1100011, 7'b1100111};
    rs2_used = opcode inside {7'b0110011, 7'b0100011, 7'b1100011};
    lu_hit   = memRead_IDEX && (rd_IDEX != 5'd0) &&
               ((rs1_used && (rs1 == rd_IDEX)) || (rs2_used && (rs2 == rd_IDEX)));
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_bubble = 1'b0;
    state_d     = state_q;
    rem_d       = rem_q;
    lu_cnt_d    = lu_cnt_q;
    fl_cnt_d    = fl_cnt_q;

    if (ext_stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
    end else if (branch_taken_EX) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = ST_RUN;
      rem_d       = 2'd0;
      fl_cnt_d    = (fl_cnt_q == '1) ? fl_cnt_q : fl_cnt_q + 1'b1;
    end else if ((state_q == ST_STALL) || lu_hit) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      lu_cnt_d    = (lu_cnt_q == '1) ? lu_cnt_q : lu_cnt_q + 1'b1;
      if (state_q == ST_RUN) begin
        // The hazard cycle itself is the first stall cycle; STALL covers the rest.
        if (LU_STALL_CYCLES > 1) begin
          state_d = ST_STALL;
          rem_d   = REM_LOAD;
        end
      end else begin
        rem_d = rem_q - 2'd1;
        if (rem_q == 2'd1) state_d = ST_RUN;
      end
    end

    if (!rst_n) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_write  = 1'b1;
      idex_bubble = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; combinational logic uses blocking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      rem_q    <= 2'd0;
      lu_cnt_q <= '0;
      fl_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      lu_cnt_q <= lu_cnt_d;
      fl_cnt_q <= fl_cnt_d;
    end
  end

  assign hz_state       = state_q;
  assign lu_stall_count = lu_cnt_q;
  assign flush_count    = fl_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core. Sits beside the ID stage and issues the per-cycle write-enable, bubble and flush controls for the PC, IF/ID and ID/EX pipeline registers. Three events drive it:
- load-use RAW hazards, detected between the instruction in IF/ID and a load in ID/EX;
- taken branches, resolved in EX;
- an external freeze request, e.g. memory wait.

It also keeps saturating performance counters for load-use stall cycles and flush cycles.

## Interface
- LU_STALL_CYCLES, 1, load-use stall length in cycles; legal 1..3 (1 = MEM-to-EX forwarding present).
- CNT_W, 16, width of each performance counter.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- instr_IFID  in  32  instruction currently in IF/ID.
- rd_IDEX  in  5  destination register of the instruction in ID/EX.
- memRead_IDEX  in  1  instruction in ID/EX is a load.
- branch_taken_EX  in  1  branch/jump in EX resolved taken this cycle.
- ext_stall  in  1  freeze request for the whole front end.
- pc_write  out  1  PC register load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a NOP (0x00000013) instead of the fetched word.
- idex_write  out  1  ID/EX load enable.
- idex_bubble  out  1  ID/EX loads zero control bits (branch, memRead, mem2reg, memWrite, RegWrite = 0).
- hz_state  out  2  FSM state: 0 RUN, 1 STALL.
- lu_stall_count  out  CNT_W  load-use stall cycles since reset.
- flush_count  out  CNT_W  flush cycles since reset.

## Operation
- Source-register use is decoded from instr_IFID[6:0]:
  - rs1 ([19:15]) is used by opcodes 0110011, 0010011, 0000011, 0100011, 1100011 and 1100111.
  - rs2 ([24:20]) is used by 0110011, 0100011 and 1100011.
  - LUI, AUIPC, JAL and unknown opcodes use neither.
- lu_hit = memRead_IDEX & (rd_IDEX != 0) & ((rs1_used & rs1 == rd_IDEX) | (rs2_used & rs2 == rd_IDEX)). Register x0 never causes a hazard.
- Default outputs: pc_write = ifid_write = idex_write = 1, ifid_flush = idex_bubble = 0.
- Priority, evaluated each cycle, highest first:
  1. **ext_stall = 1 (freeze):** pc_write = ifid_write = idex_write = 0; flush and bubble = 0. FSM state, down-counter and performance counters hold.
  2. **branch_taken_EX = 1 (flush):**
     - pc_write = 1, ifid_flush = 1, idex_bubble = 1.
     - Next state RUN; down-counter cleared.
     - flush_count += 1.
  3. **Load-use stall:** applies when in RUN with lu_hit = 1, or whenever in STALL.
     - pc_write = ifid_write = 0, idex_bubble = 1.
     - lu_stall_count += 1.
- FSM and down-counter (rem, 2 bits):
  - RUN with lu_hit and no higher-priority event: if LU_STALL_CYCLES = 1, stay in RUN; otherwise go to STALL with rem = LU_STALL_CYCLES - 1.
  - STALL: rem decrements each non-frozen cycle. When rem = 1, next state is RUN.
  - In STALL, lu_hit is not re-evaluated.
- Counters saturate at 2^CNT_W - 1 and never wrap.
- hz_state and the counters are registered. All control outputs are combinational from the inputs plus registered state, so they are valid in the same cycle as the hazard.

## Timing
- Reset: when rst_n = 0 at a rising edge, the next state is:
  - hz_state = RUN, rem = 0, lu_stall_count = 0, flush_count = 0.
- While rst_n = 0, control outputs take their default values.
- Reset asserted in the middle of a STALL aborts it; the first cycle after reset is RUN.
- A load-use hazard costs exactly LU_STALL_CYCLES non-frozen cycles of stall outputs.
- A branch flush costs 1 cycle.
- Cycles frozen by ext_stall add to both latencies and are counted in neither counter.
- Simultaneous events:
  - branch_taken_EX together with lu_hit: flush only; lu_stall_count does not increment.
  - ext_stall together with branch_taken_EX: freeze only; the branch stays in EX and is handled the next non-frozen cycle.

## Test plan
- **Single-cycle stall:** LU_STALL_CYCLES = 1; ID/EX holds `lw x5` (memRead = 1, rd = 5), IF/ID holds `add x6,x5,x7` (0x00728333). Required: exactly 1 cycle with pc_write = 0, ifid_write = 0, idex_bubble = 1; hz_state stays 0; lu_stall_count = 1.
- **Multi-cycle stall and x0/rs2 rules:** LU_STALL_CYCLES = 3, same pair. Required: 3 consecutive stall cycles, hz_state = 1 during cycles 2-3, lu_stall_count = 3. With rd_IDEX = 0, or with IF/ID holding LUI x5: no stall. With a store whose rs2 = rd_IDEX: stall.
- **Branch flush over a hazard:** branch_taken_EX = 1 in the same cycle as lu_hit. Required: ifid_flush = 1, idex_bubble = 1, pc_write = 1 for 1 cycle; flush_count = 1; lu_stall_count = 0.
- **Freeze inside a stall:** with LU_STALL_CYCLES = 2, assert ext_stall for 2 cycles in the middle of the stall. Required: all write enables = 0 while frozen; the stall resumes afterwards; total stall cycles = 2; lu_stall_count = 2.
- **Reset in STALL:** drive rst_n = 0 for 1 cycle while hz_state = 1. Required: next cycle hz_state = 0, both counters = 0, outputs at default values.
- **Saturation:** CNT_W = 4, 20 consecutive flushes. Required: flush_count stops at 15.
